// File: rtl/float_sigmoid_vector_seq.sv
// float_sigmoid_vector_seq
//   Streams a latched vector of VEC_LEN fp32 values into a float_sigmoid_single
//   core, one element per transfer, and gathers the in-order results back into
//   a vector. One start pulse per vector; vec_done pulses when the vector is full.
//
// Ports
//   clk, rst_n       clock, async active-low reset
//   start            begin a vector (sampled in IDLE only)
//   vec_in           VEC_LEN x 32b operands, element i at [32*i+31:32*i]
//   busy             state != IDLE
//   vec_done         one-cycle completion pulse
//   vec_out          VEC_LEN x 32b results, held until overwritten
//   err              watchdog timeout flag (0 unless SIGMOID_TIMEOUT_EN)
//   core_din/valid   operand channel to the core
//   core_ready       core can take an operand this cycle
//   core_done/dout   in-order result channel from the core
//
// Build option
//   SIGMOID_TIMEOUT_EN  adds a RUN-state watchdog (TIMEOUT cycles without an
//                       issue or result aborts the vector and sets err).

// One 32b element register; used for both the operand and result buffers.
module float_sigmoid_vector_seq_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
endmodule

module float_sigmoid_vector_seq #(
  parameter int VEC_LEN = 16,
  parameter int IDX_W   = $clog2(VEC_LEN+1),
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [32*VEC_LEN-1:0] vec_in,
  output logic                 busy,
  output logic                 vec_done,
  output logic [32*VEC_LEN-1:0] vec_out,
  output logic                 err,
  output logic [31:0]          core_din,
  output logic                 core_valid,
  input  logic                 core_ready,
  input  logic                 core_done,
  input  logic [31:0]          core_dout
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LEN  = IDX_W'(VEC_LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(VEC_LEN-1);

  logic [1:0]               state, state_nxt;
  logic [IDX_W-1:0]         issue_cnt, recv_cnt;
  logic                     accept, xfer, capture, tmo;
  logic [VEC_LEN-1:0][31:0] in_buf, out_buf;

  assign accept     = (state == S_IDLE) && start;
  assign core_valid = (state == S_RUN) && (issue_cnt < LEN);
  assign xfer       = core_valid && core_ready;
  // recv_cnt guard drops surplus results instead of wrapping the write index
  assign capture    = (state == S_RUN) && core_done && (recv_cnt < LEN);

  assign busy     = (state != S_IDLE);
  assign vec_done = (state == S_DONE);
  assign vec_out  = out_buf;

  // operand mux straight off the registers; forced to 0 when not offering
  always_comb begin
    core_din = '0;
    if (core_valid)
      for (int i = 0; i < VEC_LEN; i++)
        if (issue_cnt == IDX_W'(i)) core_din = in_buf[i];
  end

`ifdef SIGMOID_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT+1);
  logic [WD_W-1:0] wdog;
  logic            err_q;

  // fires on the cycle the count would reach TIMEOUT with nothing happening
  assign tmo = (state == S_RUN) && !xfer && !core_done &&
               (wdog == WD_W'(TIMEOUT-1));
  assign err = err_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else if (state == S_RUN) begin
      if (xfer || core_done) wdog <= '0;
      else if (tmo) begin
        wdog  <= '0;
        err_q <= 1'b1;
      end else wdog <= wdog + WD_W'(1);
    end
`else
  // no watchdog: constant-false abort, err tied low
  assign tmo = (TIMEOUT < 0);
  assign err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (capture && (recv_cnt == LAST)) state_nxt = S_DONE;
        else if (tmo)                      state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else if (state == S_RUN) begin
        if (xfer)    issue_cnt <= issue_cnt + IDX_W'(1);
        if (capture) recv_cnt  <= recv_cnt + IDX_W'(1);
      end
    end

  for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
    float_sigmoid_vector_seq_lane u_in (
      .clk  (clk),
      .rst_n(rst_n),
      .load (accept),
      .d    (vec_in[32*i +: 32]),
      .q    (in_buf[i])
    );
    float_sigmoid_vector_seq_lane u_out (
      .clk  (clk),
      .rst_n(rst_n),
      .load (capture && (recv_cnt == IDX_W'(i))),
      .d    (core_dout),
      .q    (out_buf[i])
    );
  end
endmodule

// File: tb/tb_float_sigmoid_vector_seq.sv
// Directed bench for float_sigmoid_vector_seq (VEC_LEN=4). A behavioural core
// stub returns each operand 5 cycles after its transfer (echo, or 0.5 for a
// zero operand in sigmoid mode), with optional ready stall and result drop.
// Cycle n = the period after edge n-1, where edge 0 samples start.
module tb_float_sigmoid_vector_seq;
  localparam int VL = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [127:0]   vec_in = '0;
  logic           busy, vec_done, err, core_valid, core_done;
  logic [127:0]   vec_out;
  logic [31:0]    core_din, core_dout;
  logic           core_ready = 1'b1;

  float_sigmoid_vector_seq #(.VEC_LEN(VL), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_in(vec_in),
    .busy(busy), .vec_done(vec_done), .vec_out(vec_out), .err(err),
    .core_din(core_din), .core_valid(core_valid), .core_ready(core_ready),
    .core_done(core_done), .core_dout(core_dout)
  );

  always #5 clk = ~clk;

  // core stub
  logic       half_mode = 1'b0, drop_en = 1'b0, bp_en = 1'b0;
  logic [4:0] dpipe;
  logic [4:0][31:0] dat_pipe;
  logic [4:0][2:0]  tag_pipe;
  logic [2:0] tag_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dpipe <= '0; dat_pipe <= '0; tag_pipe <= '0; tag_cnt <= '0;
    end else begin
      for (int k = 4; k > 0; k--) begin
        dpipe[k]    <= dpipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
      dpipe[0]    <= core_valid && core_ready;
      dat_pipe[0] <= (half_mode && core_din == 32'h0) ? 32'h3f000000 : core_din;
      tag_pipe[0] <= tag_cnt;
      tag_cnt     <= start ? 3'd0 : tag_cnt + 3'(core_valid && core_ready);
    end
  assign core_done = dpipe[4] && !(drop_en && tag_pipe[4] == 3'd2);
  assign core_dout = dat_pipe[4];

  // monitor
  int cyc = 0, t0 = 0, rel;
  int done_cnt, done_cyc, busy_fall, n_iss;
  int iss_cyc [8];
  logic prev_busy = 1'b0, stall_vld;
  logic [31:0] stall_din;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rel = cyc - t0 + 1;
    core_ready = !(bp_en && rel >= 2 && rel <= 4);
    if (vec_done) begin done_cnt++; done_cyc = rel; end
    if (core_valid && core_ready) begin
      if (n_iss < 8) iss_cyc[n_iss] = rel;
      n_iss++;
    end
    if (bp_en && rel == 3) begin stall_vld = core_valid; stall_din = core_din; end
    if (prev_busy && !busy) busy_fall = rel;
    prev_busy = busy;
  end

  int n_run = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_vec(input logic [127:0] v);
    @(negedge clk);
    done_cnt = 0; done_cyc = -1; busy_fall = -1; n_iss = 0;
    vec_in = v; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0;
  endtask

  localparam logic [127:0] V1 = {32'h40000000, 32'hbf800000, 32'h3f800000, 32'h00000000};
  localparam logic [127:0] V2 = {32'h41200000, 32'hc0400000, 32'h3e800000, 32'h42c80000};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", vec_done, 0);
    chk("rst_vout", vec_out, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", core_valid, 0);
    chk("rst_din", core_din, 0);
    rst_n = 1'b1;

    // basic vector
    start_vec(V1);
    repeat (14) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("basic_iss%0d", i), iss_cyc[i], i + 1);
    chk("basic_done_cyc", done_cyc, 10);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_vout", vec_out, V1);
    chk("basic_busy_fall", busy_fall, 11);
    chk("basic_err", err, 0);

    // zero vector through sigmoid-behaving stub -> all 0.5
    half_mode = 1'b1;
    start_vec('0);
    repeat (14) @(negedge clk);
    chk("half_vout", vec_out, {4{32'h3f000000}});
    half_mode = 1'b0;

    // backpressure in cycles 2..4
    bp_en = 1'b1;
    start_vec(V1);
    repeat (18) @(negedge clk);
    chk("bp_stall_vld", stall_vld, 1);
    chk("bp_stall_din", stall_din, 32'h3f800000);
    chk("bp_iss1", iss_cyc[1], 5);
    chk("bp_iss3", iss_cyc[3], 7);
    chk("bp_done_cyc", done_cyc, 13);
    chk("bp_vout", vec_out, V1);
    bp_en = 1'b0;

    // second start in cycle 3 is ignored
    start_vec(V1);
    repeat (3) @(negedge clk);
    vec_in = V2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_done_cyc", done_cyc, 10);
    chk("ign_vout", vec_out, V1);

    // reset in cycle 6
    start_vec(V2);
    repeat (6) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", vec_done, 0);
    chk("mrst_vout", vec_out, 0);
    chk("mrst_valid", core_valid, 0);
    chk("mrst_din", core_din, 0);
    chk("mrst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("mrst_no_done", done_cnt, 0);
    start_vec(V2);
    repeat (14) @(negedge clk);
    chk("mrst_re_done", done_cyc, 10);
    chk("mrst_re_vout", vec_out, V2);

`ifdef SIGMOID_TIMEOUT_EN
    // 3rd result dropped; last event is result 3 in cycle 9
    drop_en = 1'b1;
    start_vec(V1);
    begin
      int k = 0;
      while (busy && k < 200) begin @(negedge clk); k++; end
    end
    chk("tmo_bound", busy, 0);
    chk("tmo_err", err, 1);
    chk("tmo_no_done", done_cnt, 0);
    chk("tmo_fall_window", (busy_fall >= 25 && busy_fall <= 35), 1);
    chk("tmo_partial", vec_out[63:0], V1[63:0]);
    drop_en = 1'b0;
    start_vec(V2);
    chk("tmo_err_clr", err, 0);
    repeat (14) @(negedge clk);
    chk("tmo_re_vout", vec_out, V2);
    chk("tmo_re_done", done_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
